// File: rtl/batch_sequencer.sv
// Batch sequencer: streams NX x-words per sample into nx, runs one forward pass, writes one y row.
// Optional busy-cycle counter port "cycles" is enabled by defining BATCH_SEQ_CYCLE_CNT_EN.
module batch_sequencer #(
   parameter int unsigned    N      = 16,
   parameter int unsigned    A      = 32,
   parameter int unsigned    NX     = 2,
   parameter int unsigned    NY     = 2,
   parameter int unsigned    RD_LAT = 1,
   parameter logic [A-1:0]   X_BASE = '0,
   parameter logic [A-1:0]   Y_BASE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N-1:0]      batch,
   output logic              busy,
   output logic              done,
   output logic [A-1:0]      x_addr,
   input  logic [N-1:0]      x_dout,
   output logic [N*NX-1:0]   nx,
   output logic              calc_start,
   input  logic              calc_done,
   input  logic [N*NY-1:0]   ly,
   output logic [A-1:0]      y_addr,
   output logic [N*NY-1:0]   y_din,
   output logic              y_we,
   output logic [N-1:0]      sample
`ifdef BATCH_SEQ_CYCLE_CNT_EN
   ,
   output logic [31:0]       cycles
`endif
);

   localparam int unsigned CW = $clog2(NX + 1);

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, CALC, WRITE, FIN} state_t;

   state_t              state_q, state_d;
   logic [N-1:0]        bcnt_q, bcnt_d;
   logic [A-1:0]        x_ptr_q, x_ptr_d;
   logic [A-1:0]        y_ptr_q, y_ptr_d;
   logic [N-1:0]        sample_q, sample_d;
   logic [CW-1:0]       icnt_q, icnt_d;
   logic [CW-1:0]       wcnt_q, wcnt_d;
   logic [RD_LAT-1:0]   vld_q, vld_d;
   logic [N*NX-1:0]     nx_q, nx_d;
   logic [N*NY-1:0]     ydin_q, ydin_d;
   logic                busy_q, busy_d;
   logic                cfirst_q, cfirst_d;
   logic                issue;
   logic                cap;
`ifdef BATCH_SEQ_CYCLE_CNT_EN
   logic [31:0]         cycles_q, cycles_d;
`endif

   // Oldest tap of the valid pipe marks x_dout as belonging to an issued read
   assign cap = vld_q[RD_LAT-1];

   always_comb begin
      state_d  = state_q;
      bcnt_d   = bcnt_q;
      x_ptr_d  = x_ptr_q;
      y_ptr_d  = y_ptr_q;
      sample_d = sample_q;
      icnt_d   = icnt_q;
      wcnt_d   = wcnt_q;
      nx_d     = nx_q;
      ydin_d   = ydin_q;
      busy_d   = busy_q;
      issue    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               bcnt_d = batch;
               if (batch == '0) begin
                  state_d = FIN;
               end else begin
                  state_d  = FETCH;
                  x_ptr_d  = X_BASE;
                  y_ptr_d  = Y_BASE;
                  sample_d = '0;
                  icnt_d   = '0;
                  wcnt_d   = '0;
                  busy_d   = 1'b1;
               end
            end
         end
         FETCH: begin
            issue   = 1'b1;
            x_ptr_d = x_ptr_q + A'(1);
            icnt_d  = icnt_q + CW'(1);
            if (icnt_q == CW'(NX - 1)) state_d = DRAIN;
         end
         DRAIN: begin
            if (cap && (wcnt_q == CW'(NX - 1))) state_d = CALC;
         end
         CALC: begin
            if (calc_done) begin
               ydin_d  = ly;
               state_d = WRITE;
            end
         end
         WRITE: begin
            y_ptr_d  = y_ptr_q + A'(1);
            sample_d = sample_q + N'(1);
            icnt_d   = '0;
            wcnt_d   = '0;
            state_d  = (sample_q == bcnt_q - N'(1)) ? FIN : FETCH;
         end
         FIN: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (cap) wcnt_d = wcnt_q + CW'(1);
      for (int k = 0; k < NX; k++) begin
         if (cap && (wcnt_q == CW'(k))) nx_d[k*N +: N] = x_dout;
      end

      vld_d[0] = issue;
      for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];

      cfirst_d = (state_d == CALC) && (state_q != CALC);
   end

`ifdef BATCH_SEQ_CYCLE_CNT_EN
   always_comb begin
      cycles_d = cycles_q;
      if ((state_q == IDLE) && start) cycles_d = '0;
      else if (busy_q && (cycles_q != 32'hFFFF_FFFF)) cycles_d = cycles_q + 32'd1;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         bcnt_q   <= '0;
         x_ptr_q  <= '0;
         y_ptr_q  <= '0;
         sample_q <= '0;
         icnt_q   <= '0;
         wcnt_q   <= '0;
         vld_q    <= '0;
         nx_q     <= '0;
         ydin_q   <= '0;
         busy_q   <= 1'b0;
         cfirst_q <= 1'b0;
`ifdef BATCH_SEQ_CYCLE_CNT_EN
         cycles_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         bcnt_q   <= bcnt_d;
         x_ptr_q  <= x_ptr_d;
         y_ptr_q  <= y_ptr_d;
         sample_q <= sample_d;
         icnt_q   <= icnt_d;
         wcnt_q   <= wcnt_d;
         vld_q    <= vld_d;
         nx_q     <= nx_d;
         ydin_q   <= ydin_d;
         busy_q   <= busy_d;
         cfirst_q <= cfirst_d;
`ifdef BATCH_SEQ_CYCLE_CNT_EN
         cycles_q <= cycles_d;
`endif
      end
   end

   assign busy       = busy_q;
   assign done       = (state_q == FIN);
   assign x_addr     = x_ptr_q;
   assign nx         = nx_q;
   assign calc_start = (state_q == CALC) && cfirst_q;
   assign y_addr     = y_ptr_q;
   assign y_din      = ydin_q;
   assign y_we       = (state_q == WRITE);
   assign sample     = sample_q;
`ifdef BATCH_SEQ_CYCLE_CNT_EN
   assign cycles     = cycles_q;
`endif

endmodule

// File: tb/tb_batch_sequencer.sv
// Directed bench for batch_sequencer: default instance (NX=2, RD_LAT=1) and a
// deep-latency instance (NX=4, RD_LAT=3) whose x pointer starts at the top of the address space.
module tb_batch_sequencer;
   localparam int N = 16;
   localparam int A = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance 1 signals
   logic           start1 = 1'b0;
   logic [N-1:0]   batch1 = '0;
   logic           busy1, done1, calc_start1, y_we1;
   logic [A-1:0]   x_addr1, y_addr1;
   logic [N-1:0]   x_dout1 = '0;
   logic [2*N-1:0] nx1, y_din1;
   logic           calc_done1 = 1'b0;
   logic [2*N-1:0] ly1 = '0;
   logic [N-1:0]   sample1;

   // Instance 2 signals
   logic           start2 = 1'b0;
   logic [N-1:0]   batch2 = '0;
   logic           busy2, done2, calc_start2, y_we2;
   logic [A-1:0]   x_addr2, y_addr2;
   logic [N-1:0]   x_dout2;
   logic [4*N-1:0] nx2;
   logic [2*N-1:0] y_din2;
   logic           calc_done2 = 1'b0;
   logic [2*N-1:0] ly2 = '0;
   logic [N-1:0]   sample2;
`ifdef BATCH_SEQ_CYCLE_CNT_EN
   logic [31:0]    cycles1, cycles2;
`endif

   batch_sequencer #(.N(N), .A(A), .NX(2), .NY(2), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .batch(batch1), .busy(busy1), .done(done1),
      .x_addr(x_addr1), .x_dout(x_dout1), .nx(nx1), .calc_start(calc_start1),
      .calc_done(calc_done1), .ly(ly1), .y_addr(y_addr1), .y_din(y_din1), .y_we(y_we1),
      .sample(sample1)
`ifdef BATCH_SEQ_CYCLE_CNT_EN
      , .cycles(cycles1)
`endif
   );

   batch_sequencer #(.N(N), .A(A), .NX(4), .NY(2), .RD_LAT(3), .X_BASE(32'hFFFF_FFFF)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .batch(batch2), .busy(busy2), .done(done2),
      .x_addr(x_addr2), .x_dout(x_dout2), .nx(nx2), .calc_start(calc_start2),
      .calc_done(calc_done2), .ly(ly2), .y_addr(y_addr2), .y_din(y_din2), .y_we(y_we2),
      .sample(sample2)
`ifdef BATCH_SEQ_CYCLE_CNT_EN
      , .cycles(cycles2)
`endif
   );

   // x memory for instance 1: words 3,5,7,9 at addresses 0..3, one-cycle read
   always_ff @(posedge clk) begin
      case (x_addr1)
         32'd0:   x_dout1 <= 16'd3;
         32'd1:   x_dout1 <= 16'd5;
         32'd2:   x_dout1 <= 16'd7;
         32'd3:   x_dout1 <= 16'd9;
         default: x_dout1 <= 16'd0;
      endcase
   end

   // x memory for instance 2: word = addr[15:0] + 0x0100, three-cycle read
   logic [N-1:0] rd2_s0, rd2_s1, rd2_s2;
   always_ff @(posedge clk) begin
      rd2_s0 <= x_addr2[15:0] + 16'h0100;
      rd2_s1 <= rd2_s0;
      rd2_s2 <= rd2_s1;
   end
   assign x_dout2 = rd2_s2;

   int ywe_cnt = 0;
   int done_cnt = 0;
   always_ff @(posedge clk) begin
      if (y_we1) ywe_cnt <= ywe_cnt + 1;
      if (done1) done_cnt <= done_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;

      // Reset state
      tick(); tick();
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_xaddr", x_addr1, 0);
      chk("rst_nx", nx1, 0);
      chk("rst_calc_start", calc_start1, 0);
      chk("rst_ywe", y_we1, 0);
      chk("rst_ydin", y_din1, 0);
      chk("rst_sample", sample1, 0);
      rst = 1'b0;
      tick();

      // Two-sample batch, stray start and calc_done while busy
      start1 = 1'b1; batch1 = 16'd2;
      tick();
      start1 = 1'b0; batch1 = 16'd7;
      chk("t1_busy", busy1, 1);
      chk("t1_xaddr0", x_addr1, 0);
      calc_done1 = 1'b1;
      tick();
      calc_done1 = 1'b0;
      chk("t1_xaddr1", x_addr1, 1);
      tick();
      chk("t1_cs_early", calc_start1, 0);
      tick();
      chk("t1_cs", calc_start1, 1);
      chk("t1_nx_s0", nx1, 32'h0005_0003);
      tick();
      chk("t1_cs_pulse", calc_start1, 0);
      tick(); tick();
      chk("t1_wait_ywe", y_we1, 0);
      calc_done1 = 1'b1; ly1 = 32'h1111_AAAA;
      tick();
      calc_done1 = 1'b0; ly1 = 32'hDEAD_BEEF;
      chk("t1_ywe0", y_we1, 1);
      chk("t1_yaddr0", y_addr1, 0);
      chk("t1_ydin0", y_din1, 32'h1111_AAAA);
      chk("t1_sample0", sample1, 0);
      tick();
      chk("t1_sample1", sample1, 1);
      chk("t1_ywe_off", y_we1, 0);
      chk("t1_xaddr2", x_addr1, 2);
      start1 = 1'b1; calc_done1 = 1'b1;
      tick();
      start1 = 1'b0; calc_done1 = 1'b0;
      chk("t4_xaddr3", x_addr1, 3);
      tick();
      chk("t1_nx_partial", nx1, 32'h0005_0007);
      tick();
      chk("t1_cs1", calc_start1, 1);
      chk("t1_nx_s1", nx1, 32'h0009_0007);
      calc_done1 = 1'b1; ly1 = 32'h2222_BBBB;
      tick();
      calc_done1 = 1'b0;
      chk("t1_ywe1", y_we1, 1);
      chk("t1_yaddr1", y_addr1, 1);
      chk("t1_ydin1", y_din1, 32'h2222_BBBB);
      tick();
      chk("t1_done", done1, 1);
      chk("t1_busy_fin", busy1, 1);
      tick();
      chk("t1_done_pulse", done1, 0);
      chk("t1_busy_end", busy1, 0);
      chk("t1_ywe_count", ywe_cnt, 2);
      chk("t1_done_count", done_cnt, 1);
`ifdef BATCH_SEQ_CYCLE_CNT_EN
      chk("t1_cycles", cycles1, 14);
`endif

      // Empty batch
      start1 = 1'b1; batch1 = 16'd0;
      tick();
      start1 = 1'b0;
      chk("t2_done", done1, 1);
      chk("t2_busy", busy1, 0);
      chk("t2_xaddr", x_addr1, 4);
      tick();
      chk("t2_done_pulse", done1, 0);
      chk("t2_busy_after", busy1, 0);
      chk("t2_xaddr_after", x_addr1, 4);
      chk("t2_ywe_count", ywe_cnt, 2);
      chk("t2_done_count", done_cnt, 2);
`ifdef BATCH_SEQ_CYCLE_CNT_EN
      chk("t2_cycles", cycles1, 0);
`endif

      // Reset during CALC of sample 1, then a fresh one-sample batch
      start1 = 1'b1; batch1 = 16'd2;
      tick();
      start1 = 1'b0;
      chk("t5_xaddr_base", x_addr1, 0);
      tick(); tick(); tick();
      chk("t5_cs0", calc_start1, 1);
      calc_done1 = 1'b1; ly1 = 32'h3333_CCCC;
      tick();
      calc_done1 = 1'b0;
      tick();
      chk("t5_sample1", sample1, 1);
      tick(); tick(); tick();
      chk("t5_cs1", calc_start1, 1);
      rst = 1'b1;
      #1;
      chk("t5_rst_busy", busy1, 0);
      chk("t5_rst_xaddr", x_addr1, 0);
      chk("t5_rst_nx", nx1, 0);
      chk("t5_rst_cs", calc_start1, 0);
      chk("t5_rst_yaddr", y_addr1, 0);
      chk("t5_rst_ydin", y_din1, 0);
      chk("t5_rst_sample", sample1, 0);
      tick();
      rst = 1'b0;
      start1 = 1'b1; batch1 = 16'd1;
      tick();
      start1 = 1'b0;
      chk("t5_restart_xaddr", x_addr1, 0);
      chk("t5_restart_sample", sample1, 0);
      chk("t5_restart_busy", busy1, 1);
      tick(); tick(); tick();
      chk("t5_restart_nx", nx1, 32'h0005_0003);
      calc_done1 = 1'b1; ly1 = 32'h4444_DDDD;
      tick();
      calc_done1 = 1'b0;
      chk("t5_ywe", y_we1, 1);
      chk("t5_yaddr", y_addr1, 0);
      chk("t5_ydin", y_din1, 32'h4444_DDDD);
      tick();
      chk("t5_done", done1, 1);
      tick();

      // Deep latency, wrapping x pointer
      start2 = 1'b1; batch2 = 16'd1;
      tick();
      start2 = 1'b0;
      chk("t6_xaddr_top", x_addr2, 32'hFFFF_FFFF);
      tick();
      chk("t6_xaddr_wrap", x_addr2, 0);
      lat = 0;
      for (int k = 3; k <= 20; k++) begin
         tick();
         if (calc_start2) begin
            lat = k;
            break;
         end
      end
      chk("t3_latency", lat, 8);
      chk("t3_nx_order", nx2, 64'h0102_0101_0100_00FF);
      calc_done2 = 1'b1; ly2 = 32'h5555_EEEE;
      tick();
      calc_done2 = 1'b0;
      chk("t3_ywe", y_we2, 1);
      chk("t3_yaddr", y_addr2, 0);
      chk("t3_ydin", y_din2, 32'h5555_EEEE);
      tick();
      chk("t3_done", done2, 1);
      tick();
      chk("t3_busy_end", busy2, 0);
`ifdef BATCH_SEQ_CYCLE_CNT_EN
      chk("t6_cycles", cycles2, 10);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
